// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned requests to instruction memory,
// buffers returned words in a 2-entry FIFO and handles stall, flush and redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_en,
  input  logic        PLR1_clr,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        F_valid,
  output logic [31:0] F_instr,
  output logic [31:0] F_pc
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0] r_fetch_pc;
  logic [1:0]  r_outstanding;
  logic [1:0]  r_drop;
  logic [1:0]  r_buf_count;
  logic [31:0] r_aq_pc     [2];
  logic [31:0] r_buf_pc    [2];
  logic [31:0] r_buf_instr [2];

  logic [31:0] w_fetch_pc_d;
  logic [1:0]  w_outstanding_d;
  logic [1:0]  w_drop_d;
  logic [1:0]  w_buf_count_d;
  logic [31:0] w_aq_d        [2];
  logic [31:0] w_buf_pc_d    [2];
  logic [31:0] w_buf_instr_d [2];

  logic w_rsp;
  logic w_pop;
  logic w_push;
  logic w_fire;
  logic w_credit;
  logic w_aq_idx;
  logic w_buf_idx;
  logic w_unused_redirect_lsb;

  assign w_unused_redirect_lsb = ^redirect_pc[1:0];

  // Responses with nothing in flight are stale (e.g. issued before a reset).
  assign w_rsp  = imem_rsp_valid & (r_outstanding != 2'd0);
  assign w_pop  = (r_buf_count != 2'd0) & PC_en & ~PLR1_clr;
  assign w_push = w_rsp & (r_drop == 2'd0) & ~PLR1_clr;

  // The slot freed by this cycle's pop is credited so a 1-cycle memory can stream.
  assign w_credit = (({1'b0, r_outstanding} + {1'b0, r_buf_count}) - {2'b00, w_pop}) < 3'd2;

  assign imem_req_valid = ~rst & ~PLR1_clr & w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_fire         = imem_req_valid & imem_req_ready;

  assign w_aq_idx  = (r_outstanding != 2'(w_rsp));
  assign w_buf_idx = (r_buf_count != 2'(w_pop));

  always_comb begin
    w_fetch_pc_d    = r_fetch_pc;
    w_outstanding_d = r_outstanding + 2'(w_fire) - 2'(w_rsp);
    w_drop_d        = r_drop;
    w_buf_count_d   = r_buf_count + 2'(w_push) - 2'(w_pop);
    w_aq_d          = r_aq_pc;
    w_buf_pc_d      = r_buf_pc;
    w_buf_instr_d   = r_buf_instr;

    if (w_rsp) begin
      w_aq_d[0] = r_aq_pc[1];
    end
    if (w_fire) begin
      w_aq_d[w_aq_idx] = r_fetch_pc;
      w_fetch_pc_d     = r_fetch_pc + 32'd4;
    end

    if (w_pop) begin
      w_buf_pc_d[0]    = r_buf_pc[1];
      w_buf_instr_d[0] = r_buf_instr[1];
    end
    if (w_push) begin
      w_buf_pc_d[w_buf_idx]    = r_aq_pc[0];
      w_buf_instr_d[w_buf_idx] = imem_rsp_data;
    end

    if (PLR1_clr) begin
      // Everything still in flight belongs to the squashed path.
      w_fetch_pc_d  = {redirect_pc[31:2], 2'b00};
      w_drop_d      = r_outstanding - 2'(w_rsp);
      w_buf_count_d = 2'd0;
    end else if (w_rsp && (r_drop != 2'd0)) begin
      w_drop_d = r_drop - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= 2'd0;
      r_drop        <= 2'd0;
      r_buf_count   <= 2'd0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_d;
      r_outstanding <= w_outstanding_d;
      r_drop        <= w_drop_d;
      r_buf_count   <= w_buf_count_d;
    end
  end

  // Payload storage is qualified by the counters and needs no reset.
  always_ff @(posedge clk) begin
    r_aq_pc     <= w_aq_d;
    r_buf_pc    <= w_buf_pc_d;
    r_buf_instr <= w_buf_instr_d;
  end

  assign F_valid = (r_buf_count != 2'd0);
  assign F_instr = F_valid ? r_buf_instr[0] : Nop;
  assign F_pc    = F_valid ? r_buf_pc[0] : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model whose
// responses can be held off to build up outstanding requests.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PC_en = 1'b1;
  logic        PLR1_clr = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        F_valid;
  logic [31:0] F_instr;
  logic [31:0] F_pc;
  logic        rsp_en = 1'b1;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .PC_en          (PC_en),
    .PLR1_clr       (PLR1_clr),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .F_valid        (F_valid),
    .F_instr        (F_instr),
    .F_pc           (F_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: accepted addresses queue up; head answered one cycle later when rsp_en.
  logic [31:0] mq[$];
  always begin
    @(negedge clk);
    if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
    if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
    @(posedge clk);
    #2;
    if (rsp_en && mq.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ins(mq[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle with rst=0 (c0).
  task automatic do_reset();
    tick();
    rst = 1'b1; PC_en = 1'b1; PLR1_clr = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; rsp_en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1; PC_en = 1'b1; PLR1_clr = 1'b0; imem_req_ready = 1'b1;
    tick();
    #3;
    checks++;
    if (imem_req_valid !== 1'b0)
      begin errors++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++;
    if ({F_valid, F_pc, F_instr} !== {1'b0, 32'h0, NOP})
      begin errors++; $display("FAIL reset_f got=%b %h %h exp=0 0 %h", F_valid, F_pc, F_instr, NOP); end
  endtask

  task automatic test_stream();
    do_reset();
    #3;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0})
      begin errors++; $display("FAIL stream_req0 got=%b %h exp=1 0", imem_req_valid, imem_req_addr); end
    tick(); #3;
    checks++;
    if ({imem_req_valid, imem_req_addr, F_valid} !== {1'b1, 32'h4, 1'b0})
      begin errors++; $display("FAIL stream_req4 got=%b %h fv=%b", imem_req_valid, imem_req_addr, F_valid); end
    for (int k = 0; k < 5; k++) begin
      tick(); #3;
      checks++;
      if ({F_valid, F_pc, F_instr} !== {1'b1, 32'(4 * k), ins(32'(4 * k))})
        begin errors++; $display("FAIL stream_f%0d got=%b %h %h exp pc=%h", k, F_valid, F_pc, F_instr, 4 * k); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (4) tick();
    PC_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      checks++;
      if ({F_valid, F_pc, F_instr, imem_req_valid} !== {1'b1, 32'h8, ins(32'h8), 1'b0})
        begin errors++; $display("FAIL stall_hold%0d got=%b %h %h rv=%b", k, F_valid, F_pc, F_instr, imem_req_valid); end
      tick();
    end
    PC_en = 1'b1;
    #3;
    checks++;
    if ({F_pc, imem_req_valid, imem_req_addr} !== {32'h8, 1'b1, 32'h10})
      begin errors++; $display("FAIL stall_resume got=%h %b %h exp=8 1 10", F_pc, imem_req_valid, imem_req_addr); end
    for (int k = 0; k < 3; k++) begin
      tick(); #3;
      checks++;
      if ({F_valid, F_pc, F_instr} !== {1'b1, 32'(12 + 4 * k), ins(32'(12 + 4 * k))})
        begin errors++; $display("FAIL stall_after%0d got=%b %h %h", k, F_valid, F_pc, F_instr); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    rsp_en = 1'b0; PLR1_clr = 1'b1; redirect_pc = 32'h10;
    #3;
    checks++;
    if (imem_req_valid !== 1'b0)
      begin errors++; $display("FAIL redir_block got=%b exp=0", imem_req_valid); end
    tick(); PLR1_clr = 1'b0; #3;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h10})
      begin errors++; $display("FAIL redir_req10 got=%b %h", imem_req_valid, imem_req_addr); end
    tick(); #3;
    tick(); PLR1_clr = 1'b1; redirect_pc = 32'h100; rsp_en = 1'b1; #3;
    checks++;
    if ({imem_req_valid, F_valid} !== 2'b00)
      begin errors++; $display("FAIL redir_flush got=%b %b exp=0 0", imem_req_valid, F_valid); end
    tick(); PLR1_clr = 1'b0; #3;
    checks++;
    if ({imem_req_valid, imem_req_addr, F_valid} !== {1'b1, 32'h100, 1'b0})
      begin errors++; $display("FAIL redir_req100 got=%b %h fv=%b", imem_req_valid, imem_req_addr, F_valid); end
    tick(); #3;
    checks++;
    if ({F_valid, F_pc, F_instr} !== {1'b0, 32'h0, NOP})
      begin errors++; $display("FAIL redir_dropped got=%b %h %h", F_valid, F_pc, F_instr); end
    for (int k = 0; k < 2; k++) begin
      tick(); #3;
      checks++;
      if ({F_valid, F_pc, F_instr} !== {1'b1, 32'(256 + 4 * k), ins(32'(256 + 4 * k))})
        begin errors++; $display("FAIL redir_f%0d got=%b %h %h", k, F_valid, F_pc, F_instr); end
    end
  endtask

  task automatic test_ready_stall();
    do_reset();
    repeat (3) tick();
    imem_req_ready = 1'b0;
    #3;
    checks++;
    if ({imem_req_valid, imem_req_addr, F_pc} !== {1'b1, 32'hC, 32'h4})
      begin errors++; $display("FAIL rdy_c3 got=%b %h %h", imem_req_valid, imem_req_addr, F_pc); end
    tick(); #3;
    checks++;
    if ({F_valid, F_pc, imem_req_addr} !== {1'b1, 32'h8, 32'hC})
      begin errors++; $display("FAIL rdy_c4 got=%b %h %h", F_valid, F_pc, imem_req_addr); end
    for (int k = 0; k < 3; k++) begin
      tick(); #3;
      checks++;
      if ({F_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'hC})
        begin errors++; $display("FAIL rdy_hold%0d got=%b %b %h", k, F_valid, imem_req_valid, imem_req_addr); end
    end
    tick(); imem_req_ready = 1'b1;
    tick(); #3;
    checks++;
    if ({imem_req_valid, imem_req_addr, F_valid} !== {1'b1, 32'h10, 1'b0})
      begin errors++; $display("FAIL rdy_c9 got=%b %h %b", imem_req_valid, imem_req_addr, F_valid); end
    for (int k = 0; k < 2; k++) begin
      tick(); #3;
      checks++;
      if ({F_valid, F_pc, F_instr} !== {1'b1, 32'(12 + 4 * k), ins(32'(12 + 4 * k))})
        begin errors++; $display("FAIL rdy_f%0d got=%b %h %h", k, F_valid, F_pc, F_instr); end
    end
  endtask

  task automatic test_align_wrap();
    do_reset();
    PLR1_clr = 1'b1; redirect_pc = 32'h203;
    tick(); PLR1_clr = 1'b0; #3;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h200})
      begin errors++; $display("FAIL align_req got=%b %h exp=1 200", imem_req_valid, imem_req_addr); end
    tick(); tick(); #3;
    checks++;
    if ({F_valid, F_pc, F_instr} !== {1'b1, 32'h200, ins(32'h200)})
      begin errors++; $display("FAIL align_f got=%b %h %h", F_valid, F_pc, F_instr); end
    tick(); PLR1_clr = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick(); PLR1_clr = 1'b0; #3;
    checks++;
    if ({imem_req_valid, imem_req_addr, F_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0})
      begin errors++; $display("FAIL wrap_reqtop got=%b %h %b", imem_req_valid, imem_req_addr, F_valid); end
    tick(); #3;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0})
      begin errors++; $display("FAIL wrap_req0 got=%b %h exp=1 0", imem_req_valid, imem_req_addr); end
    tick(); #3;
    checks++;
    if ({F_valid, F_pc, F_instr} !== {1'b1, 32'hFFFF_FFFC, ins(32'hFFFF_FFFC)})
      begin errors++; $display("FAIL wrap_ftop got=%b %h %h", F_valid, F_pc, F_instr); end
    tick(); #3;
    checks++;
    if ({F_valid, F_pc, F_instr} !== {1'b1, 32'h0, ins(32'h0)})
      begin errors++; $display("FAIL wrap_f0 got=%b %h %h", F_valid, F_pc, F_instr); end
  endtask

  task automatic test_back_to_back_clr();
    do_reset();
    PLR1_clr = 1'b1; redirect_pc = 32'h300;
    tick(); redirect_pc = 32'h400; #3;
    checks++;
    if (imem_req_valid !== 1'b0)
      begin errors++; $display("FAIL b2b_block got=%b exp=0", imem_req_valid); end
    tick(); PLR1_clr = 1'b0; #3;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h400})
      begin errors++; $display("FAIL b2b_req got=%b %h exp=1 400", imem_req_valid, imem_req_addr); end
    tick(); tick(); #3;
    checks++;
    if ({F_valid, F_pc, F_instr} !== {1'b1, 32'h400, ins(32'h400)})
      begin errors++; $display("FAIL b2b_f got=%b %h %h", F_valid, F_pc, F_instr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_en = 1'b0;
    tick(); tick();
    rst = 1'b1; rsp_en = 1'b1; #3;
    checks++;
    if ({imem_req_valid, F_valid} !== 2'b00)
      begin errors++; $display("FAIL rmid_inrst got=%b %b exp=0 0", imem_req_valid, F_valid); end
    tick(); rst = 1'b0; #3;
    checks++;
    if ({imem_req_valid, imem_req_addr, F_valid} !== {1'b1, 32'h0, 1'b0})
      begin errors++; $display("FAIL rmid_first got=%b %h %b", imem_req_valid, imem_req_addr, F_valid); end
    tick(); #3;
    checks++;
    if ({F_valid, F_pc, F_instr} !== {1'b0, 32'h0, NOP})
      begin errors++; $display("FAIL rmid_stale got=%b %h %h", F_valid, F_pc, F_instr); end
    for (int k = 0; k < 2; k++) begin
      tick(); #3;
      checks++;
      if ({F_valid, F_pc, F_instr} !== {1'b1, 32'(4 * k), ins(32'(4 * k))})
        begin errors++; $display("FAIL rmid_f%0d got=%b %h %h", k, F_valid, F_pc, F_instr); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_ready_stall();
    test_align_wrap();
    test_back_to_back_clr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
